// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op-mode encodings.
package addsub_pkg;

   localparam int MODE_W = 2;

   localparam logic [MODE_W-1:0] MODE_SUB_WRAP = 2'b00;
   localparam logic [MODE_W-1:0] MODE_SUB_SAT  = 2'b01;
   localparam logic [MODE_W-1:0] MODE_ADD_WRAP = 2'b10;
   localparam logic [MODE_W-1:0] MODE_ADD_SAT  = 2'b11;

endpackage

// File: rtl/addsub_core.sv
// Combinational unsigned add/subtract with wrap or saturate on over/underflow.
module addsub_core
   import addsub_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic [WIDTH-1:0]  lhs,
   input  logic [WIDTH-1:0]  rhs,
   input  logic [MODE_W-1:0] mode,
   output logic [WIDTH-1:0]  result,
   output logic              overflow
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;
   logic           is_add;
   logic           is_sat;

   always_comb begin
      sum      = {1'b0, lhs} + {1'b0, rhs};
      diff     = {1'b0, lhs} - {1'b0, rhs};
      is_add   = (mode == MODE_ADD_WRAP) || (mode == MODE_ADD_SAT);
      is_sat   = (mode == MODE_SUB_SAT)  || (mode == MODE_ADD_SAT);
      result   = '0;
      overflow = 1'b0;
      if (is_add) begin
         // bit WIDTH of the extended sum is the carry out
         overflow = sum[WIDTH];
         result   = (is_sat && overflow) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      end else begin
         // bit WIDTH of the extended difference is the borrow, i.e. lhs < rhs
         overflow = diff[WIDTH];
         result   = (is_sat && overflow) ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage add/subtract pipeline with valid/ready flow control, channel tags
// and a per-channel sticky overflow bank.
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int WIDTH    = 12,
   parameter int CHANNELS = 8,
   parameter int CH_W     = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_lhs,
   input  logic [WIDTH-1:0]    in_rhs,
   input  logic [MODE_W-1:0]   in_mode,
   input  logic [CH_W-1:0]     in_ch,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_result,
   output logic                out_overflow,
   output logic [CH_W-1:0]     out_ch,
   input  logic [CHANNELS-1:0] clr_sticky,
   output logic [CHANNELS-1:0] sticky_ovf
);

   logic                s1_valid;
   logic [WIDTH-1:0]    s1_lhs;
   logic [WIDTH-1:0]    s1_rhs;
   logic [MODE_W-1:0]   s1_mode;
   logic [CH_W-1:0]     s1_ch;

   logic                s2_valid;
   logic [WIDTH-1:0]    s2_result;
   logic                s2_ovf;
   logic [CH_W-1:0]     s2_ch;

   logic [WIDTH-1:0]    core_result;
   logic                core_ovf;
   logic                s1_adv;
   logic                s2_adv;
   logic                out_hs;
   logic [CHANNELS-1:0] set_mask;

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   // A stage advances when it is empty or the stage after it is advancing; the only
   // combinational in->out path is out_ready -> in_ready.
   always_comb begin
      s2_adv   = !s2_valid || out_ready;
      s1_adv   = !s1_valid || s2_adv;
      in_ready = s1_adv;
      out_hs   = s2_valid && out_ready;
   end

   addsub_core #(.WIDTH(WIDTH)) u_core (
      .lhs      (s1_lhs),
      .rhs      (s1_rhs),
      .mode     (s1_mode),
      .result   (core_result),
      .overflow (core_ovf)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_lhs   <= '0;
         s1_rhs   <= '0;
         s1_mode  <= '0;
         s1_ch    <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_lhs  <= in_lhs;
            s1_rhs  <= in_rhs;
            s1_mode <= in_mode;
            s1_ch   <= in_ch;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_ovf    <= 1'b0;
         s2_ch     <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_result <= core_result;
            s2_ovf    <= core_ovf;
            s2_ch     <= s1_ch;
         end
      end
   end

   // Tags beyond CHANNELS-1 match no bit, so they deliver normally without a sticky update.
   always_comb begin
      set_mask = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         set_mask[i] = out_hs && s2_ovf && (int'(s2_ch) == i);
      end
   end

   // Set is applied after clear so a simultaneous set wins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sticky_ovf <= '0;
      end else begin
         sticky_ovf <= (sticky_ovf & ~clr_sticky) | set_mask;
      end
   end

   always_comb begin
      out_valid    = s2_valid;
      out_result   = s2_result;
      out_overflow = s2_ovf;
      out_ch       = s2_ch;
   end

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed literal vectors plus a behavioural model
// checked on every output handshake and every cycle's sticky flags.
module tb_addsub_pipe;

   localparam int W    = 12;
   localparam int CHN  = 8;
   localparam int CW   = 3;
   localparam int EW   = CW + 1 + W;
   localparam int MAXV = (1 << W) - 1;

   localparam logic [1:0] M_SUB_WRAP = 2'b00;
   localparam logic [1:0] M_SUB_SAT  = 2'b01;
   localparam logic [1:0] M_ADD_WRAP = 2'b10;
   localparam logic [1:0] M_ADD_SAT  = 2'b11;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   in_lhs = '0;
   logic [W-1:0]   in_rhs = '0;
   logic [1:0]     in_mode = '0;
   logic [CW-1:0]  in_ch = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [W-1:0]   out_result;
   logic           out_overflow;
   logic [CW-1:0]  out_ch;
   logic [CHN-1:0] clr_sticky = '0;
   logic [CHN-1:0] sticky_ovf;

   addsub_pipe #(.WIDTH(W), .CHANNELS(CHN), .CH_W(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_lhs       (in_lhs),
      .in_rhs       (in_rhs),
      .in_mode      (in_mode),
      .in_ch        (in_ch),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_overflow (out_overflow),
      .out_ch       (out_ch),
      .clr_sticky   (clr_sticky),
      .sticky_ovf   (sticky_ovf)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Result from the arithmetic rules on plain integers: {ch, ovf, result}.
   function automatic logic [EW-1:0] model(input logic [W-1:0] l, input logic [W-1:0] r,
                                          input logic [1:0] m, input logic [CW-1:0] c);
      int   a;
      int   b;
      int   res;
      logic ovf;
      logic add;
      logic sat;
      a   = int'(l);
      b   = int'(r);
      add = (m == M_ADD_WRAP) || (m == M_ADD_SAT);
      sat = (m == M_SUB_SAT) || (m == M_ADD_SAT);
      if (add) begin
         res = a + b;
         ovf = res > MAXV;
         if (ovf) res = sat ? MAXV : res - (MAXV + 1);
      end else begin
         res = a - b;
         ovf = a < b;
         if (ovf) res = sat ? 0 : res + (MAXV + 1);
      end
      return {c, ovf, res[W-1:0]};
   endfunction

   // ---------------- scoreboard ----------------
   logic [EW-1:0]  exp_q[$];
   logic [EW-1:0]  held;
   logic [EW-1:0]  e;
   logic [CHN-1:0] m_sticky = '0;
   logic [CHN-1:0] nxt;
   bit             hold_pending = 0;
   int             out_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         hold_pending = 0;
         m_sticky     = '0;
      end else begin
         check("sticky", 32'(sticky_ovf), 32'(m_sticky));
         if (hold_pending) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'({out_ch, out_overflow, out_result}), 32'(held));
         end
         hold_pending = out_valid && !out_ready;
         held         = {out_ch, out_overflow, out_result};
         nxt = m_sticky;
         for (int i = 0; i < CHN; i++) if (clr_sticky[i]) nxt[i] = 1'b0;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 32'({out_ch, out_overflow, out_result}), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("out", 32'({out_ch, out_overflow, out_result}), 32'(e));
               out_cnt++;
               if (e[W]) nxt[e[EW-1:W+1]] = 1'b1;
            end
         end
         m_sticky = nxt;
         if (in_valid && in_ready) exp_q.push_back(model(in_lhs, in_rhs, in_mode, in_ch));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_op(input logic [W-1:0] l, input logic [W-1:0] r, input logic [1:0] m,
                        input logic [CW-1:0] c, input logic [W-1:0] er, input logic eo,
                        input logic [CHN-1:0] clr);
      @(posedge clk); #1;
      in_valid = 1'b1; in_lhs = l; in_rhs = r; in_mode = m; in_ch = c; out_ready = 1'b1;
      check("op_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_lhs   = W'($urandom);
      in_rhs   = W'($urandom);
      in_mode  = 2'($urandom);
      in_ch    = CW'($urandom);
      @(posedge clk); #1;
      check("op_valid", 32'(out_valid), 32'd1);
      check("op_result", 32'(out_result), 32'(er));
      check("op_ovf", 32'(out_overflow), 32'(eo));
      check("op_ch", 32'(out_ch), 32'(c));
      clr_sticky = clr;
      @(posedge clk); #1;
      clr_sticky = '0;
      check("op_drained", 32'(out_valid), 32'd0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 4))
         0: return '0;
         1: return W'(MAXV);
         2: return W'(1 << (W - 1));
         default: return W'($urandom);
      endcase
   endfunction

   // ---------------- stimulus ----------------
   bit hs;
   int idx;
   int start;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_sticky", 32'(sticky_ovf), 32'd0);
      check("rst_out_result", 32'(out_result), 32'd0);

      check("model_sub_wrap", 32'(model(12'h005, 12'h00A, M_SUB_WRAP, 3'd3)), 32'h7FFB);
      check("model_add_sat", 32'(model(12'hFFF, 12'h001, M_ADD_SAT, 3'd1)), 32'h3FFF);
      check("model_add_wrap", 32'(model(12'hFFF, 12'h001, M_ADD_WRAP, 3'd0)), 32'h1000);
      check("model_sub_eq", 32'(model(12'h800, 12'h800, M_SUB_SAT, 3'd0)), 32'h0000);

      do_op(12'h005, 12'h00A, M_SUB_WRAP, 3'd3, 12'hFFB, 1'b1, 8'h00);
      check("sticky_set", 32'(sticky_ovf), 32'h08);
      do_op(12'h005, 12'h00A, M_SUB_SAT, 3'd3, 12'h000, 1'b1, 8'h08);
      check("sticky_set_wins", 32'(sticky_ovf), 32'h08);
      @(posedge clk); #1 clr_sticky = 8'h08;
      @(posedge clk); #1 clr_sticky = 8'h00;
      check("sticky_clear", 32'(sticky_ovf), 32'h00);
      do_op(12'hFFF, 12'h001, M_ADD_SAT, 3'd1, 12'hFFF, 1'b1, 8'h00);
      check("sticky_ch1", 32'(sticky_ovf), 32'h02);
      do_op(12'hFFF, 12'h001, M_ADD_WRAP, 3'd2, 12'h000, 1'b1, 8'h00);
      check("sticky_ch2", 32'(sticky_ovf), 32'h06);
      do_op(12'h800, 12'h800, M_SUB_WRAP, 3'd5, 12'h000, 1'b0, 8'h00);
      do_op(12'h800, 12'h800, M_SUB_SAT, 3'd6, 12'h000, 1'b0, 8'h00);
      do_op(12'h123, 12'h456, M_ADD_WRAP, 3'd0, 12'h579, 1'b0, 8'h00);
      do_op(12'hFFE, 12'h001, M_ADD_SAT, 3'd7, 12'hFFF, 1'b0, 8'h00);
      do_op(12'h00A, 12'h005, M_SUB_SAT, 3'd4, 12'h005, 1'b0, 8'h00);
      check("sticky_no_ovf", 32'(sticky_ovf), 32'h06);
      do_op(12'h000, 12'hFFF, M_SUB_WRAP, 3'd0, 12'h001, 1'b1, 8'h00);
      check("sticky_ch0", 32'(sticky_ovf), 32'h07);

      // back-to-back 16 ops with a 5-cycle output stall
      idx   = 0;
      hs    = 0;
      start = out_cnt;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         if (hs) idx++;
         in_valid = (idx < 16);
         in_lhs   = W'(idx * 12'h111);
         in_rhs   = 12'h880;
         in_mode  = 2'(idx % 4);
         in_ch    = CW'(idx % 8);
         out_ready = !(c >= 4 && c < 9);
         @(negedge clk);
         if (c >= 4 && c < 9) check("stall_in_ready", 32'(in_ready), 32'd0);
         hs = in_valid && in_ready;
      end
      check("b2b_count", 32'(out_cnt - start), 32'd16);
      check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

      // reset with both stages full
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1;
      in_lhs = 12'h001; in_rhs = 12'h002; in_mode = M_SUB_WRAP; in_ch = 3'd5;
      @(posedge clk); #1;
      in_lhs = 12'hF00; in_rhs = 12'h200; in_mode = M_ADD_WRAP; in_ch = 3'd6;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      check("pre_rst_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_sticky", 32'(sticky_ovf), 32'd0);
      check("mid_rst_out_result", 32'(out_result), 32'd0);
      check("mid_rst_out_ovf", 32'(out_overflow), 32'd0);
      check("mid_rst_out_ch", 32'(out_ch), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         check("no_stale_out", 32'(out_valid), 32'd0);
      end

      // random traffic against the model
      start = out_cnt;
      for (int c = 0; c < 40000 && (out_cnt - start) < 10000; c++) begin
         @(posedge clk); #1;
         in_valid   = ($urandom_range(0, 99) < 70);
         in_lhs     = pick();
         in_rhs     = pick();
         in_mode    = 2'($urandom_range(0, 3));
         in_ch      = CW'($urandom_range(0, CHN - 1));
         out_ready  = ($urandom_range(0, 99) < 70);
         clr_sticky = ($urandom_range(0, 15) == 0) ? CHN'($urandom) : '0;
      end
      check("rand_count", 32'((out_cnt - start) >= 10000), 32'd1);
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      clr_sticky = '0;
      repeat (4) @(posedge clk);
      #1 check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
